// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter and its scoreboard.
package wb_write_arbiter_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int CNT_W     = 4;

  localparam logic [RF_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

endpackage

// File: rtl/wb_write_arbiter_scoreboard.sv
// Pending-destination bits for outstanding divides; a same-edge set beats a clear.
module wb_write_arbiter_scoreboard
  import wb_write_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [RF_ADDR_W-1:0] set_rd,
  input  logic                 clr_en,
  input  logic [RF_ADDR_W-1:0] clr_rd,
  output logic [NUM_REGS-1:0]  busy
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
    logic set_hit;
    logic clr_hit;
    // x0 is never tracked: it can never be a real destination.
    assign set_hit = set_en && (set_rd == RF_ADDR_W'(gi)) && (set_rd != X0);
    assign clr_hit = clr_en && (clr_rd == RF_ADDR_W'(gi));
    assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy = busy_reg;

endmodule

// File: rtl/wb_write_arbiter.sv
// Shares the single register-file write port between the WB stage and the divider,
// buffering one divider result that gains priority after MAX_WAIT cycles.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int MAX_WAIT   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_write_enable,
  input  logic [RF_ADDR_W-1:0]  wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  input  logic                  div_issue_valid,
  input  logic [RF_ADDR_W-1:0]  div_issue_rd,
  input  logic                  div_valid,
  input  logic [RF_ADDR_W-1:0]  div_rd,
  input  logic [DATA_WIDTH-1:0] div_result,
  output logic                  div_ready,
  output logic                  rf_write_enable,
  output logic [RF_ADDR_W-1:0]  rf_rd,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  wb_stall,
  output logic [NUM_REGS-1:0]   sb_busy
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [RF_ADDR_W-1:0]  hold_rd_reg, hold_rd_next;
  logic [DATA_WIDTH-1:0] hold_data_reg, hold_data_next;

  logic wb_live;
  logic div_live;
  logic sel_wb;
  logic sel_div;
  logic sel_hold;
  logic ready_c;
  logic stall_c;

  assign wb_live  = wb_write_enable && (wb_rd != X0);
  assign div_live = div_valid && (div_rd != X0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      hold_rd_reg   <= '0;
      hold_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hold_rd_reg   <= hold_rd_next;
      hold_data_reg <= hold_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hold_rd_next   = hold_rd_reg;
    hold_data_next = hold_data_reg;
    sel_wb         = 1'b0;
    sel_div        = 1'b0;
    sel_hold       = 1'b0;
    ready_c        = 1'b0;
    stall_c        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready_c = 1'b1;
        sel_wb  = wb_live;
        // Results to x0 are simply consumed here; only real destinations are buffered.
        if (div_live) begin
          if (wb_live) begin
            hold_rd_next   = div_rd;
            hold_data_next = div_result;
            cnt_next       = CNT_W'(1);
            state_next     = (MAX_WAIT_C <= CNT_W'(1)) ? ST_FORCE : ST_HELD;
          end else begin
            sel_div = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (wb_live) begin
          sel_wb   = 1'b1;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg + CNT_W'(1) >= MAX_WAIT_C) begin
            state_next = ST_FORCE;
          end
        end else begin
          sel_hold       = 1'b1;
          cnt_next       = '0;
          hold_rd_next   = '0;
          hold_data_next = '0;
          state_next     = ST_IDLE;
        end
      end
      ST_FORCE: begin
        sel_hold       = 1'b1;
        stall_c        = wb_live;
        cnt_next       = '0;
        hold_rd_next   = '0;
        hold_data_next = '0;
        state_next     = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held so no stray write escapes.
  always_comb begin
    rf_write_enable = 1'b0;
    rf_rd           = '0;
    rf_write_data   = '0;
    if (rst_n) begin
      if (sel_hold) begin
        rf_write_enable = 1'b1;
        rf_rd           = hold_rd_reg;
        rf_write_data   = hold_data_reg;
      end else if (sel_wb) begin
        rf_write_enable = 1'b1;
        rf_rd           = wb_rd;
        rf_write_data   = wb_write_data;
      end else if (sel_div) begin
        rf_write_enable = 1'b1;
        rf_rd           = div_rd;
        rf_write_data   = div_result;
      end
    end
  end

  assign div_ready = rst_n & ready_c;
  assign wb_stall  = rst_n & stall_c;

  wb_write_arbiter_scoreboard u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_en (div_issue_valid),
    .set_rd (div_issue_rd),
    .clr_en (sel_div | sel_hold),
    .clr_rd (sel_hold ? hold_rd_reg : div_rd),
    .busy   (sb_busy)
  );

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed vector table plus randomized traffic checked against an age-based reference model.
module tb_wb_write_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_write_enable;
  logic [4:0]  wb_rd;
  logic [31:0] wb_write_data;
  logic        div_issue_valid;
  logic [4:0]  div_issue_rd;
  logic        div_valid;
  logic [4:0]  div_rd;
  logic [31:0] div_result;
  logic        div_ready;
  logic        rf_write_enable;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data;
  logic        wb_stall;
  logic [31:0] sb_busy;

  always #5 clk = ~clk;

  wb_write_arbiter #(.MAX_WAIT(MAX_WAIT), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb_write_enable (wb_write_enable),
    .wb_rd           (wb_rd),
    .wb_write_data   (wb_write_data),
    .div_issue_valid (div_issue_valid),
    .div_issue_rd    (div_issue_rd),
    .div_valid       (div_valid),
    .div_rd          (div_rd),
    .div_result      (div_result),
    .div_ready       (div_ready),
    .rf_write_enable (rf_write_enable),
    .rf_rd           (rf_rd),
    .rf_write_data   (rf_write_data),
    .wb_stall        (wb_stall),
    .sb_busy         (sb_busy)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        iv;
    logic [4:0]  ird;
    logic        dv;
    logic [4:0]  drd;
    logic [31:0] dres;
    logic        e_rfe;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_ready;
    logic [31:0] e_sb;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: at most one buffered result and its age in cycles.
  logic        m_held_v;
  logic [4:0]  m_held_rd;
  logic [31:0] m_held_data;
  int          m_age;
  logic [31:0] m_sb;

  function automatic vec_t mk(input logic we, input logic [4:0] wrd, input logic [31:0] wdata,
                              input logic iv, input logic [4:0] ird,
                              input logic dv, input logic [4:0] drd, input logic [31:0] dres,
                              input logic e_rfe, input logic [4:0] e_rd, input logic [31:0] e_data,
                              input logic e_stall, input logic e_ready, input logic [31:0] e_sb);
    vec_t v;
    v.we = we; v.wrd = wrd; v.wdata = wdata; v.iv = iv; v.ird = ird;
    v.dv = dv; v.drd = drd; v.dres = dres;
    v.e_rfe = e_rfe; v.e_rd = e_rd; v.e_data = e_data;
    v.e_stall = e_stall; v.e_ready = e_ready; v.e_sb = e_sb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input logic rfe, input logic [4:0] rd,
                         input logic [31:0] data, input logic stall, input logic ready,
                         input logic [31:0] sb);
    chk({tag, ".rf_we"},  32'(rf_write_enable), 32'(rfe));
    chk({tag, ".rf_rd"},  32'(rf_rd),           32'(rd));
    chk({tag, ".rf_data"}, rf_write_data,       data);
    chk({tag, ".stall"},  32'(wb_stall),        32'(stall));
    chk({tag, ".ready"},  32'(div_ready),       32'(ready));
    chk({tag, ".sb"},     sb_busy,              sb);
  endtask

  task automatic set_inputs(input logic we, input logic [4:0] wrd, input logic [31:0] wdata,
                            input logic iv, input logic [4:0] ird,
                            input logic dv, input logic [4:0] drd, input logic [31:0] dres);
    wb_write_enable = we; wb_rd = wrd; wb_write_data = wdata;
    div_issue_valid = iv; div_issue_rd = ird;
    div_valid = dv; div_rd = drd; div_result = dres;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".rf_we"},   32'(rf_write_enable), 32'd0);
    chk({tag, ".rf_rd"},   32'(rf_rd),           32'd0);
    chk({tag, ".rf_data"}, rf_write_data,        32'd0);
    chk({tag, ".stall"},   32'(wb_stall),        32'd0);
    chk({tag, ".sb"},      sb_busy,              32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_inputs(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    #1;
    reset_checks("reset");
    $display("txn reset outputs rf_we=%0d sb=0x%h", rf_write_enable, sb_busy);
    @(negedge clk);
    rst_n = 1'b1;

    //                we    wrd    wdata          iv    ird    dv    drd    dres               rfe   rd     data           st    rdy   sb
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b1, 5'd5, 32'h7,          1'b1, 5'd5, 32'h7,         1'b0, 1'b1, 32'h20));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd6, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b1, 5'd3, 32'h11,        1'b0, 5'd0, 1'b1, 5'd6, 32'hDEADBEEF,   1'b1, 5'd3, 32'h11,        1'b0, 1'b1, 32'h40));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd6, 32'hDEADBEEF,  1'b0, 1'b0, 32'h40));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b1, 5'd1, 32'h101,       1'b0, 5'd0, 1'b1, 5'd7, 32'h77,         1'b1, 5'd1, 32'h101,       1'b0, 1'b1, 32'h80));
    tbl.push_back(mk(1'b1, 5'd2, 32'h102,       1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd2, 32'h102,       1'b0, 1'b0, 32'h80));
    tbl.push_back(mk(1'b1, 5'd3, 32'h103,       1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd3, 32'h103,       1'b0, 1'b0, 32'h80));
    tbl.push_back(mk(1'b1, 5'd4, 32'h104,       1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd4, 32'h104,       1'b0, 1'b0, 32'h80));
    tbl.push_back(mk(1'b1, 5'd5, 32'h105,       1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd7, 32'h77,        1'b1, 1'b0, 32'h80));
    tbl.push_back(mk(1'b1, 5'd5, 32'h105,       1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd5, 32'h105,       1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd8, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b1, 5'd9, 32'h9,         1'b0, 5'd0, 1'b1, 5'd8, 32'h88,         1'b1, 5'd9, 32'h9,         1'b0, 1'b1, 32'h100));
    tbl.push_back(mk(1'b1, 5'd0, 32'h55,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd8, 32'h88,        1'b0, 1'b0, 32'h100));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 1'b1, 5'd9, 32'h99,         1'b1, 5'd9, 32'h99,        1'b0, 1'b1, 32'h200));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h200));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b1, 5'd9, 32'h9A,         1'b1, 5'd9, 32'h9A,        1'b0, 1'b1, 32'h200));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b1, 5'd2, 32'h22,        1'b0, 5'd0, 1'b1, 5'd0, 32'h1234,       1'b1, 5'd2, 32'h22,        1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b1, 5'd0, 32'h66,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b1, 5'd0, 32'h5,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 32'h0));

    foreach (tbl[i]) begin
      @(negedge clk);
      set_inputs(tbl[i].we, tbl[i].wrd, tbl[i].wdata, tbl[i].iv, tbl[i].ird,
                 tbl[i].dv, tbl[i].drd, tbl[i].dres);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_rfe, tbl[i].e_rd, tbl[i].e_data,
              tbl[i].e_stall, tbl[i].e_ready, tbl[i].e_sb);
      $display("txn vec%0d rf_we=%0d rd=x%0d data=0x%h stall=%0d ready=%0d sb=0x%h",
               i, rf_write_enable, rf_rd, rf_write_data, wb_stall, div_ready, sb_busy);
    end

    // Reset arriving while a result is buffered must discard it without a write.
    @(negedge clk);
    set_inputs(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    set_inputs(1'b1, 5'd1, 32'h201, 1'b0, 5'd0, 1'b1, 5'd10, 32'hAA);
    #1;
    chk_all("rsthold.capture", 1'b1, 5'd1, 32'h201, 1'b0, 1'b1, 32'h400);
    @(negedge clk);
    set_inputs(1'b1, 5'd2, 32'h202, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    #1;
    chk_all("rsthold.held", 1'b1, 5'd2, 32'h202, 1'b0, 1'b0, 32'h400);
    rst_n = 1'b0;
    #1;
    reset_checks("rsthold.async");
    $display("txn reset-in-held rf_we=%0d sb=0x%h", rf_write_enable, sb_busy);
    @(negedge clk);
    rst_n = 1'b1;
    set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    #1;
    chk_all("rsthold.after", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    #1;
    chk_all("rsthold.idle", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);

    // Randomized traffic against the reference model.
    m_held_v = 1'b0; m_held_rd = '0; m_held_data = '0; m_age = 0; m_sb = '0;
    begin
      logic        dreq_v = 1'b0;
      logic [4:0]  dreq_rd = '0;
      logic [31:0] dreq_data = '0;
      logic        last_stall = 1'b0;
      for (int c = 0; c < 400; c++) begin
        logic        live, e_rfe, e_stall, e_ready, clr;
        logic [4:0]  e_rd, clr_rd;
        logic [31:0] e_data;
        @(negedge clk);
        if (!dreq_v && $urandom_range(0, 2) == 0) begin
          dreq_v    = 1'b1;
          dreq_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          dreq_data = $urandom();
        end
        if (!last_stall) begin
          wb_write_enable = 1'($urandom_range(0, 1));
          wb_rd           = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          wb_write_data   = $urandom();
        end
        div_issue_valid = ($urandom_range(0, 3) == 0);
        div_issue_rd    = 5'($urandom_range(0, 31));
        div_valid       = dreq_v;
        div_rd          = dreq_rd;
        div_result      = dreq_data;
        #1;

        live = wb_write_enable && (wb_rd != 5'd0);
        e_rfe = 1'b0; e_rd = '0; e_data = '0; e_stall = 1'b0;
        e_ready = !m_held_v; clr = 1'b0; clr_rd = '0;
        if (m_held_v) begin
          if (m_age >= MAX_WAIT || !live) begin
            e_rfe = 1'b1; e_rd = m_held_rd; e_data = m_held_data;
            e_stall = live; clr = 1'b1; clr_rd = m_held_rd; m_held_v = 1'b0;
          end else begin
            e_rfe = 1'b1; e_rd = wb_rd; e_data = wb_write_data; m_age++;
          end
        end else begin
          if (live) begin
            e_rfe = 1'b1; e_rd = wb_rd; e_data = wb_write_data;
          end
          if (div_valid && div_rd != 5'd0) begin
            if (live) begin
              m_held_v = 1'b1; m_held_rd = div_rd; m_held_data = div_result; m_age = 1;
            end else begin
              e_rfe = 1'b1; e_rd = div_rd; e_data = div_result; clr = 1'b1; clr_rd = div_rd;
            end
          end
        end

        chk_all($sformatf("rnd%0d", c), e_rfe, e_rd, e_data, e_stall, e_ready, m_sb);
        $display("txn rnd%0d wb=%0d/x%0d div=%0d/x%0d rf_we=%0d rd=x%0d data=0x%h stall=%0d ready=%0d",
                 c, wb_write_enable, wb_rd, div_valid, div_rd, rf_write_enable, rf_rd,
                 rf_write_data, wb_stall, div_ready);

        if (clr) m_sb[clr_rd] = 1'b0;
        if (div_issue_valid && div_issue_rd != 5'd0) m_sb[div_issue_rd] = 1'b1;
        if (e_ready) dreq_v = 1'b0;
        last_stall = e_stall;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Owns the single register-file write port of the RV32IM pipeline.
- Shares the port between the in-order WB stage and the multi-cycle M-extension divide unit, which returns results out of order.
- Buffers one divider result and forces a stall on the WB stage if that result waits too long.
- Keeps a 32-entry pending-destination scoreboard that the hazard unit reads.

Parameters:
- MAX_WAIT, 4: cycles a buffered divider result may wait before it takes priority (range 1-15).
- DATA_WIDTH, 32: write-data width.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- WB_WRITE_ENABLE  in  1  WB stage write request
- WB_RD  in  5  WB destination register
- WB_WRITE_DATA  in  DATA_WIDTH  WB write data
- DIV_ISSUE_VALID  in  1  a divide/remainder instruction enters the divider this cycle
- DIV_ISSUE_RD  in  5  destination of the issued divide
- DIV_VALID  in  1  divider result available
- DIV_RD  in  5  divider result destination
- DIV_RESULT  in  DATA_WIDTH  divider result
- DIV_READY  out  1  arbiter accepts the divider result this cycle
- RF_WRITE_ENABLE  out  1  register-file write strobe
- RF_RD  out  5  register-file write address
- RF_WRITE_DATA  out  DATA_WIDTH  register-file write data
- WB_STALL  out  1  WB write not performed this cycle; hold the MEM/WB register
- SB_BUSY  out  32  bit n = 1 means a divide to xn is outstanding

Behaviour:
- Definitions: a WB request is live when WB_WRITE_ENABLE=1 and WB_RD!=0. A write to x0 is never issued to the register file.
- Reset (RST=0, asynchronous): state=IDLE, hold register cleared, wait counter=0, SB_BUSY=0.
- Reset output values: RF_WRITE_ENABLE=0, RF_RD=0, RF_WRITE_DATA=0, WB_STALL=0. DIV_READY=1 once RST is deasserted.
- Reset asserted mid-operation discards the hold register and the scoreboard.
- State machine states:
  - IDLE: hold register empty.
  - HELD: holds {rd, data}, wait counter running.
  - FORCE: hold register has priority.
- IDLE behaviour:
  - DIV_READY=1.
  - If DIV_VALID and no live WB request: divider result written combinationally in the same cycle (bypass, zero latency); stay in IDLE.
  - If DIV_VALID and a live WB request: WB is written; the divider result is captured into the hold register; go to HELD with counter=1.
  - WB request alone: written directly, WB_STALL=0.
- HELD behaviour:
  - DIV_READY=0.
  - If no live WB request: the held result is written; go to IDLE.
  - Otherwise WB is written and the counter increments.
  - When the counter reaches MAX_WAIT at a clock edge, go to FORCE.
- FORCE behaviour:
  - DIV_READY=0.
  - The held result is written and the next state is IDLE.
  - If a WB request is live that cycle: WB_STALL=1 (combinational), its write is dropped, and the pipeline re-presents it next cycle.
- RF outputs: combinational mux of the selected source. When nothing is written, RF_WRITE_ENABLE=0 and RF_RD/RF_WRITE_DATA=0.
- Divider results to x0: accepted (DIV_READY applies) and never written. In IDLE they are consumed; they are never captured into the hold register.
- Scoreboard:
  - DIV_ISSUE_VALID with DIV_ISSUE_RD!=0 sets the bit at the next edge.
  - The bit clears at the edge on which that rd's divider result is written (bypass or drain).
  - Simultaneous set and clear of the same rd: set wins, because the newer issue is outstanding.
- At most one divider result is outstanding in the hold register; the divider must keep DIV_VALID and its data stable until DIV_READY=1.
- Worst-case divider result latency through the arbiter: MAX_WAIT+1 cycles.

Decomposition:
- Shared package: state encoding constants (IDLE/HELD/FORCE), the RF address width (5), and the x0 index constant.
- Natural sub-module: wb_scoreboard, a 32-bit set/clear register with set-priority. The arbiter FSM, hold register and mux stay in the top module.

Test Plan:
- Reset with all inputs idle -> all outputs 0, DIV_READY=1 after RST deasserts, SB_BUSY=0.
- DIV_ISSUE rd=5; later DIV_VALID rd=5 data=0x0000_0007 with no WB request -> RF write x5=7 in the same cycle, SB_BUSY[5] 1->0.
- DIV_VALID rd=6 data=0xDEAD_BEEF with concurrent WB rd=3 data=0x11 -> x3=0x11 written, result held, DIV_READY=0; next cycle has no WB -> x6=0xDEAD_BEEF written, state returns to IDLE.
- MAX_WAIT=4, held rd=7 with continuous WB writes to x1..x4:
  - writes to x1..x4 proceed;
  - the 5th cycle writes x7, WB_STALL=1 and WB x5 is dropped;
  - the next cycle writes WB x5.
- WB_WRITE_ENABLE=1 with WB_RD=0 while a result is held -> the held result drains immediately and no x0 write occurs.
- Same-cycle issue rd=9 and divider write to rd=9 -> SB_BUSY[9] stays 1. Assert RST while in HELD -> hold register and SB_BUSY cleared immediately, with no spurious RF write.
